mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Successor to the purely combinational ALU multiply path. Adds correct signed multiply, signed and unsigned divide, and MTHI/MTLO writes.
- Sits beside the ALU in EX. The pipeline stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32: operand and HI/LO width, even and ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; not for override.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high. Clears all state.
- start, input, 1: request an operation. Sampled only when `busy`=0.
- op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opA, input, WIDTH: rs; the dividend for divides.
- opB, input, WIDTH: rt; the divisor for divides.
- mtHi, input, 1: write `wdata` into HI.
- mtLo, input, 1: write `wdata` into LO.
- wdata, input, WIDTH: MTHI/MTLO data.
- busy, output, 1: operation in flight.
- done, output, 1: one-cycle pulse; new `hi`/`lo` are visible in this cycle.
- hi, output, WIDTH: HI register. Multiply: upper product. Divide: remainder.
- lo, output, WIDTH: LO register. Multiply: lower product. Divide: quotient.

Behaviour:
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 at edge E0: latch op, sign flags, magnitudes (|x| for signed ops, raw value for unsigned), divide-by-zero flag; counter←WIDTH; go to CALC; `busy`=1 from E0.
- CALC:
  - One shift-add (multiply) or restoring subtract (divide) step per edge; counter decrements.
  - When counter reaches 1, the next edge goes to FIX.
- FIX:
  - One edge writes `hi`/`lo` after sign correction, asserts `done` for that cycle, clears `busy`, returns to IDLE.
  - Latency: `start` at E0 → results and `done` after edge E(WIDTH+1). Next `start` is accepted in the `done` cycle.
- Signed multiply: product is the 2·WIDTH-bit two's complement; negated when sign(opA)≠sign(opB).
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/−1: lo=MIN, hi=0.
- Divide by zero, both signs: lo = all ones, hi = opA. Same latency; no exception.
- `start` while `busy`: ignored, no queueing.
- `mtHi`/`mtLo` in IDLE: register written at the next edge. `done` is not asserted.
- `mtHi`/`mtLo` while `busy`: ignored.
- `mtHi`/`mtLo` with `start` in the same IDLE cycle: the MT write happens at E0, then the operation overwrites both registers at completion.
- `hi`/`lo` hold their previous values throughout CALC. Intermediate state is internal.
- `reset` mid-operation: immediately IDLE, all outputs return to reset values, no `done`.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute a full single-cycle signed/unsigned product.
  - IDLE goes directly to FIX; results and `done` appear after edge E1, `busy` high for one cycle.
  - Divide is unchanged.
- Undefined: multiply uses the iterative path, latency WIDTH+1.

Decomposition:
- Shared package/header `MDU.v`:
  - op encodings MDU_MULT / MDU_MULTU / MDU_DIV / MDU_DIVU;
  - state encodings MDU_IDLE / MDU_CALC / MDU_FIX;
  - the MDU_FAST_MUL_EN guard.
- One sub-module, `mdu_step`: combinational single iteration. Inputs: mode, partial accumulator, operand bit. Outputs: next accumulator and next shifted operand.
- Top level owns the FSM, counter, sign fix-up and HI/LO.

Test Plan (WIDTH=32, macro undefined unless stated):
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `done` 33 cycles after `start`; `busy` high for exactly 33 cycles.
- MULT 0xFFFFFFFD×0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9÷2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7÷2 → lo=3, hi=1.
- DIV 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5÷0 → lo=0xFFFFFFFF, hi=5.
- Second `start` and `mtHi`=1 (wdata=0x1234) at cycle 10 of a DIVU → both ignored, first result intact. Then `mtLo` 0xABCD in IDLE → lo=0xABCD next cycle, `done`=0. Reset asserted mid-MULT → hi=lo=0, busy=0, no `done`.
- MDU_FAST_MUL_EN defined: MULTU 0x10000×0x10000 → hi=1, lo=0, `done` one cycle after `start`. DIVU 100÷7 still takes 33 cycles → lo=14, hi=2.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
// Build option: MDU_FAST_MUL_EN selects the single-cycle multiply path in mul_div_unit.
package mul_div_unit_pkg;

  // op[1] selects divide, op[0] selects unsigned.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned shift-add multiply / restoring divide datapath.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: div (mode), acc (partial HI), opnd (multiplier or dividend/quotient),
//        addend (multiplicand or divisor), acc_nxt/opnd_nxt (next iteration).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] opnd_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (opnd[0] ? {1'b0, addend} : '0);
    shifted  = {acc, opnd[WIDTH-1]};
    diff     = shifted - {1'b0, addend};
    acc_nxt  = sum[WIDTH:1];
    opnd_nxt = {sum[0], opnd[WIDTH-1:1]};
    if (div) begin
      // Remainder stays below the divisor, so bit WIDTH of diff is the borrow.
      if (!diff[WIDTH]) begin
        acc_nxt  = diff[WIDTH-1:0];
        opnd_nxt = {opnd[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt  = shifted[WIDTH-1:0];
        opnd_nxt = {opnd[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Latency: WIDTH+1 edges from start to done (multiply takes 1 edge with MDU_FAST_MUL_EN).
// Backpressure: start and mtHi/mtLo are ignored while busy; no queueing.
// Ports: clk, reset (async high), start/op/opA/opB request, mtHi/mtLo/wdata direct
//        writes, busy/done status, hi/lo registers (product or remainder/quotient).
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             mtHi,
  input  logic             mtLo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_a, neg_b, dz;
  logic [WIDTH-1:0] acc, opnd, bval;
  logic [WIDTH-1:0] acc_step, opnd_step;

  logic             a_neg, b_neg, fast_go;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign a_neg = ~op[0] & opA[WIDTH-1];
  assign b_neg = ~op[0] & opB[WIDTH-1];
  assign a_mag = a_neg ? -opA : opA;
  assign b_mag = b_neg ? -opB : opB;

`ifdef MDU_FAST_MUL_EN
  assign fast_go = ~op[1];
`else
  assign fast_go = 1'b0;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div     (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .addend  (bval),
    .acc_nxt (acc_step),
    .opnd_nxt(opnd_step)
  );

  // Sign correction of the magnitude result. A zero divisor leaves the
  // quotient all ones and the remainder re-signed back to opA.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -{acc, opnd} : {acc, opnd};
    quot_fix = dz ? '1 : ((neg_a ^ neg_b) ? -opnd : opnd);
    rem_fix  = neg_a ? -acc : acc;
  end

  assign busy = (state != MDU_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = fast_go ? MDU_FIX : MDU_CALC;
      MDU_CALC: if (cnt == CNT_W'(1)) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      bval   <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (mtHi) hi <= wdata;
          if (mtLo) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_a  <= a_neg;
            neg_b  <= b_neg;
            dz     <= op[1] && (opB == '0);
            bval   <= b_mag;
            cnt    <= CNT_W'(WIDTH);
            acc    <= '0;
            opnd   <= a_mag;
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) {acc, opnd} <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
          end
        end
        MDU_CALC: begin
          acc  <= acc_step;
          opnd <= opnd_step;
          cnt  <= cnt - CNT_W'(1);
        end
        MDU_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32.
// Latency: expectations follow MDU_FAST_MUL_EN when defined.
// Backpressure: exercises start/MT writes while busy.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, mtHi, mtLo, busy, done;
  logic [1:0]  op;
  logic [31:0] opA, opB, wdata, hi, lo;
  int          checks = 0;
  int          errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .mtHi(mtHi), .mtLo(mtLo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then advance until done (bounded). lat counts edges after E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    op = o; opA = a; opB = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; op = 0; opA = 0; opB = 0; mtHi = 0; mtLo = 0; wdata = 0;
    step(); step();
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mul();
    int lat, bcnt;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    checks++; if (lat !== MUL_LAT)     begin errors++; $display("FAIL multu_lat got %0d want %0d", lat, MUL_LAT); end
    checks++; if (bcnt !== MUL_LAT)    begin errors++; $display("FAIL multu_busy got %0d want %0d", bcnt, MUL_LAT); end
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007, lat, bcnt);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    issue(2'b00, 32'h00000005, 32'hFFFFFFFA, lat, bcnt);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFE2) begin errors++; $display("FAIL mult_neg_b got %h%h want ffffffffffffffe2", hi, lo); end
    issue(2'b01, 32'h00010000, 32'h00010000, lat, bcnt);
    checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL multu_2p32 got %h_%h want 00000001_00000000", hi, lo); end
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL multu_2p32_lat got %0d want %0d", lat, MUL_LAT); end
  endtask

  task automatic test_div();
    int lat, bcnt;
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, bcnt);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg got lo=%h hi=%h want fffffffd ffffffff", lo, hi); end
    issue(2'b11, 32'd7, 32'd2, lat, bcnt);
    checks++; if (lo !== 32'd3 || hi !== 32'd1) begin errors++; $display("FAIL divu_7_2 got lo=%h hi=%h want 3 1", lo, hi); end
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL div_min got lo=%h hi=%h want 80000000 0", lo, hi); end
    issue(2'b11, 32'd5, 32'd0, lat, bcnt);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'd5) begin errors++; $display("FAIL divu_zero got lo=%h hi=%h want ffffffff 5", lo, hi); end
    issue(2'b10, 32'hFFFFFFF9, 32'd0, lat, bcnt);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL div_zero got lo=%h hi=%h want ffffffff fffffff9", lo, hi); end
    issue(2'b11, 32'd100, 32'd7, lat, bcnt);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_100_7 got lo=%h hi=%h want 14 2", lo, hi); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_lat got %0d want 33", lat); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    mtHi = 1; mtLo = 1; wdata = 32'h55;
    step();
    mtHi = 0; mtLo = 0;
    checks++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL mt_both got %h %h want 55 55", hi, lo); end
    op = 2'b11; opA = 32'd100; opB = 32'd7; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 9; i++) step();
    op = 2'b01; opA = 32'd3; opB = 32'd3; start = 1; mtHi = 1; wdata = 32'h1234;
    step();
    start = 0; mtHi = 0;
    checks++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL hold_calc got %h %h want 55 55", hi, lo); end
    lat = 0;
    while (!done && lat < 100) begin step(); lat++; end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL busy_ignore got lo=%h hi=%h want 14 2", lo, hi); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL no_queue got busy=%b done=%b want 0 0", busy, done); end
    mtLo = 1; wdata = 32'hABCD;
    step();
    mtLo = 0;
    checks++; if (lo !== 32'hABCD || hi !== 32'd2) begin errors++; $display("FAIL mtlo got lo=%h hi=%h want abcd 2", lo, hi); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done got %b want 0", done); end
  endtask

  task automatic test_mt_with_start();
    int lat;
    op = 2'b11; opA = 32'd9; opB = 32'd4; start = 1; mtHi = 1; wdata = 32'h77;
    step();
    start = 0; mtHi = 0;
    checks++; if (hi !== 32'h77) begin errors++; $display("FAIL mt_at_e0 got %h want 77", hi); end
    lat = 0;
    while (!done && lat < 100) begin step(); lat++; end
    checks++; if (lo !== 32'd2 || hi !== 32'd1) begin errors++; $display("FAIL mt_overwrite got lo=%h hi=%h want 2 1", lo, hi); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    issue(2'b11, 32'd50, 32'd8, lat, bcnt);
    // issue() returns inside the done cycle, so this start lands there.
    issue(2'b11, 32'd23, 32'd5, lat, bcnt);
    checks++; if (lo !== 32'd4 || hi !== 32'd3) begin errors++; $display("FAIL b2b got lo=%h hi=%h want 4 3", lo, hi); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_lat got %0d want 33", lat); end
  endtask

  task automatic test_reset_mid();
    int seen;
    op = 2'b00; opA = 32'h1234; opB = 32'h5678; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 5; i++) step();
    reset = 1;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy); end
    step();
    reset = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_done got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_busy_ignore();
    test_mt_with_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
